// File: rtl/ball_motion.sv
// ball_motion: Pong ball engine advancing one step per rising edge of the game clock,
// bouncing off walls and paddles and flagging misses as score pulses.
module ball_motion #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_X_L  = 8,
  parameter int PADDLE_X_R  = 624,
  parameter int SERVE_TICKS = 60
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       game_clk,
  input  logic       start,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit,
  output logic       score_l,
  output logic       score_r,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORED} state_t;
  localparam int CW = $clog2(SERVE_TICKS + 1);
  localparam logic [9:0] X_C = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] Y_C = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [10:0] LF = 11'(PADDLE_X_L + PADDLE_W);
  localparam logic [10:0] PXR = 11'(PADDLE_X_R);
  localparam logic [10:0] PH = 11'(PADDLE_H);
  localparam logic [10:0] HR = 11'(H_RES);
  localparam logic [10:0] VR = 11'(V_RES);
  state_t state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic dx_q, dx_d, dy_q, dy_d, gclk_q;
  logic hit_q, hit_d, score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick, ov_l, ov_r, bnc_l, bnc_r, miss_l, miss_r, y_hi, y_lo, last;
  logic [10:0] bx, by, pl, pr;
  // all geometry is compared in 11 bits so sums never wrap
  always_comb begin
    tick = game_clk & ~gclk_q;
    bx = {1'b0, ball_x_q};
    by = {1'b0, ball_y_q};
    pl = {1'b0, paddle_l_y};
    pr = {1'b0, paddle_r_y};
    ov_l = (by + BS > pl) && (by < pl + PH);
    ov_r = (by + BS > pr) && (by < pr + PH);
    bnc_l = (bx >= LF) && (bx - SP <= LF) && ov_l;
    bnc_r = (bx + BS <= PXR) && (bx + BS + SP >= PXR) && ov_r;
    miss_l = bx < SP;
    miss_r = bx + BS + SP > HR;
    y_hi = by + BS + SP >= VR;
    y_lo = by < SP;
    last = cnt_q == CW'(SERVE_TICKS - 1);
  end
  always_comb begin
    state_d = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    cnt_d = cnt_q;
    hit_d = 1'b0;
    score_l_d = 1'b0;
    score_r_d = 1'b0;
    case (state_q)
      IDLE: begin
        ball_x_d = X_C;
        ball_y_d = Y_C;
        if (start) begin
          state_d = SERVE;
          cnt_d = '0;
        end
      end
      SERVE: begin
        ball_x_d = X_C;
        ball_y_d = Y_C;
        if (tick) begin
          cnt_d = last ? '0 : cnt_q + 1'b1;
          state_d = last ? PLAY : SERVE;
        end
      end
      PLAY: if (tick) begin
        ball_y_d = dy_q ? (y_hi ? 10'(VR - BS) : 10'(by + SP)) : (y_lo ? 10'd0 : 10'(by - SP));
        dy_d = dy_q ? ~y_hi : y_lo;
        if (!dx_q) begin
          if (bnc_l) begin
            ball_x_d = 10'(LF);
            dx_d = 1'b1;
            hit_d = 1'b1;
          end else if (miss_l) begin
            score_r_d = 1'b1;
            state_d = SCORED;
          end else ball_x_d = 10'(bx - SP);
        end else begin
          if (bnc_r) begin
            ball_x_d = 10'(PXR - BS);
            dx_d = 1'b0;
            hit_d = 1'b1;
          end else if (miss_r) begin
            score_l_d = 1'b1;
            state_d = SCORED;
          end else ball_x_d = 10'(bx + SP);
        end
      end
      SCORED: begin
        ball_x_d = X_C;
        ball_y_d = Y_C;
        cnt_d = '0;
        dx_d = ~score_r_q;
        state_d = SERVE;
      end
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ball_x_q <= X_C;
      ball_y_q <= Y_C;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
      cnt_q <= '0;
      gclk_q <= 1'b0;
      hit_q <= 1'b0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      cnt_q <= cnt_d;
      gclk_q <= game_clk;
      hit_q <= hit_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end
  assign ball_x = ball_x_q;
  assign ball_y = ball_y_q;
  assign hit = hit_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign state = state_q;
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed checks of serve timing, wall/paddle bounces, misses and resets.
module tb_ball_motion;
  logic clk_in = 1'b0;
  logic rst_n, game_clk, start;
  logic [9:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
  logic hit, score_l, score_r;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;
  ball_motion dut (
    .clk_in(clk_in), .rst_n(rst_n), .game_clk(game_clk), .start(start),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .hit(hit),
    .score_l(score_l), .score_r(score_r), .state(state)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  // one game_clk rising edge; returns one cycle after the tick edge so pulses are visible
  task automatic tick();
    game_clk = 1'b0;
    @(negedge clk_in);
    game_clk = 1'b1;
    @(negedge clk_in);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    game_clk = 1'b0;
    start = 1'b0;
    paddle_l_y = '0;
    paddle_r_y = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      game_clk = ~game_clk;
    end
    check("rst_x", ball_x, 316);
    check("rst_y", ball_y, 236);
    check("rst_state", state, 0);
    check("rst_hit", hit, 0);
    check("rst_score_l", score_l, 0);
    check("rst_score_r", score_r, 0);
    game_clk = 1'b0;
    rst_n = 1'b1;
    @(negedge clk_in);
    tick();
    check("idle_no_start", state, 0);
    pulse_start();
    check("serve_entry", state, 1);
    ticks(59);
    check("serve_59", state, 1);
    tick();
    check("play_60", state, 2);
    check("play_60_x", ball_x, 316);
    tick();
    check("move1_x", ball_x, 318);
    check("move1_y", ball_y, 238);
    repeat (3) @(negedge clk_in);
    check("gclk_high_hold", ball_x, 318);
    game_clk = 1'b0;
    repeat (3) @(negedge clk_in);
    check("gclk_fall_hold", ball_x, 318);
    ticks(116);
    check("move117_x", ball_x, 550);
    check("move117_y", ball_y, 470);
    pulse_start();
    check("start_in_play", state, 2);
    check("start_in_play_x", ball_x, 550);
    tick();
    check("wall_clamp_y", ball_y, 472);
    check("wall_clamp_x", ball_x, 552);
    tick();
    check("wall_bounce_y", ball_y, 470);
    ticks(30);
    check("move149_x", ball_x, 614);
    check("move149_y", ball_y, 410);
    paddle_r_y = 10'd402;
    tick();
    check("rbounce_x", ball_x, 616);
    check("rbounce_y", ball_y, 408);
    check("rbounce_hit", hit, 1);
    @(negedge clk_in);
    check("rbounce_hit_clr", hit, 0);
    paddle_l_y = 10'd400;
    tick();
    check("after_rb_x", ball_x, 614);
    check("after_rb_y", ball_y, 406);
    ticks(298);
    check("left_run_x", ball_x, 18);
    check("left_run_y", ball_y, 188);
    tick();
    check("lpass_x", ball_x, 16);
    check("lpass_hit", hit, 0);
    ticks(8);
    check("left_edge_x", ball_x, 0);
    check("left_edge_y", ball_y, 206);
    tick();
    check("lmiss_state", state, 3);
    check("lmiss_score_r", score_r, 1);
    check("lmiss_score_l", score_l, 0);
    @(negedge clk_in);
    check("lmiss_serve", state, 1);
    check("lmiss_x", ball_x, 316);
    check("lmiss_y", ball_y, 236);
    check("lmiss_pulse_clr", score_r, 0);
    ticks(60);
    check("serve2_play", state, 2);
    ticks(3);
    rst_n = 1'b0;
    @(negedge clk_in);
    check("midrst_state", state, 0);
    check("midrst_x", ball_x, 316);
    check("midrst_y", ball_y, 236);
    rst_n = 1'b1;
    paddle_r_y = '0;
    @(negedge clk_in);
    pulse_start();
    ticks(60);
    check("game3_play", state, 2);
    ticks(150);
    check("rpass_x", ball_x, 616);
    check("rpass_y", ball_y, 408);
    check("rpass_hit", hit, 0);
    ticks(8);
    check("right_edge_x", ball_x, 632);
    check("right_edge_y", ball_y, 392);
    tick();
    check("rmiss_state", state, 3);
    check("rmiss_score_l", score_l, 1);
    check("rmiss_score_r", score_r, 0);
    @(negedge clk_in);
    check("rmiss_serve", state, 1);
    check("rmiss_x", ball_x, 316);
    check("rmiss_y", ball_y, 236);
    check("rmiss_pulse_clr", score_l, 0);
    ticks(60);
    tick();
    check("dy_kept_y", ball_y, 234);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
